button_debounce_start: RTL

//  Conditions the raw push-button that arms the SAFE multiplexed display. It

---
 rtl/button_debounce_start_if.sv | 24 ++
 rtl/button_debounce_start.sv | 127 ++++++++++++
 2 files changed

// File: rtl/button_debounce_start_if.sv
// Button-side signal bundle: the raw pin going in and the conditioned level/strobes coming out.
interface button_debounce_start_if;
   logic btn;
   logic btn_db;
   logic press_pulse;
   logic release_pulse;
   logic start;

   modport master (
      output btn,
      input  btn_db,
      input  press_pulse,
      input  release_pulse,
      input  start
   );

   modport slave (
      input  btn,
      output btn_db,
      output press_pulse,
      output release_pulse,
      output start
   );
endinterface

// File: rtl/button_debounce_start.sv
// Push-button conditioner: two-flop synchroniser, counter-qualified debounce FSM,
// press/release strobes and the start level that enables the seven-segment driver.
module button_debounce_start #(
   parameter int STABLE_CYCLES = 1_000_000,
   parameter bit TOGGLE        = 1'b1
) (
   input  logic                    clock,
   input  logic                    reset,
   button_debounce_start_if.slave  bus
);

   localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   typedef enum logic [1:0] {
      IDLE,
      RISE_CHK,
      HIGH,
      FALL_CHK
   } state_t;

   logic             r_s1;
   logic             r_s2;
   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_btnDb;
   logic             r_press;
   logic             r_release;
   logic             r_start;

   state_t           w_nextState;
   logic [CNT_W-1:0] w_nextCnt;
   logic             w_pressEvt;
   logic             w_releaseEvt;
   logic             w_btnDbNext;
   logic             w_startNext;

   // Only r_s2 is allowed to reach the FSM; r_s1 may be metastable.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_s1      <= 1'b0;
         r_s2      <= 1'b0;
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_btnDb   <= 1'b0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_start   <= 1'b0;
      end else begin
         r_s1      <= bus.btn;
         r_s2      <= r_s1;
         r_state   <= w_nextState;
         r_cnt     <= w_nextCnt;
         r_btnDb   <= w_btnDbNext;
         r_press   <= w_pressEvt;
         r_release <= w_releaseEvt;
         r_start   <= w_startNext;
      end
   end

   // The counter restarts on every state change, so it tops out at CNT_LAST and never wraps.
   always_comb begin
      w_nextState  = r_state;
      w_nextCnt    = r_cnt;
      w_pressEvt   = 1'b0;
      w_releaseEvt = 1'b0;
      unique case (r_state)
         IDLE: begin
            if (r_s2) begin
               w_nextState = RISE_CHK;
               w_nextCnt   = CNT_ONE;
            end
         end
         RISE_CHK: begin
            if (!r_s2) begin
               w_nextState = IDLE;
               w_nextCnt   = '0;
            end else if (r_cnt == CNT_LAST) begin
               w_nextState = HIGH;
               w_nextCnt   = '0;
               w_pressEvt  = 1'b1;
            end else begin
               w_nextCnt   = r_cnt + CNT_ONE;
            end
         end
         HIGH: begin
            if (!r_s2) begin
               w_nextState = FALL_CHK;
               w_nextCnt   = CNT_ONE;
            end
         end
         FALL_CHK: begin
            if (r_s2) begin
               w_nextState  = HIGH;
               w_nextCnt    = '0;
            end else if (r_cnt == CNT_LAST) begin
               w_nextState  = IDLE;
               w_nextCnt    = '0;
               w_releaseEvt = 1'b1;
            end else begin
               w_nextCnt    = r_cnt + CNT_ONE;
            end
         end
         default: begin
            w_nextState = IDLE;
            w_nextCnt   = '0;
         end
      endcase
   end

   // The debounced level is high in both states that follow an accepted press.
   always_comb begin
      w_btnDbNext = (w_nextState == HIGH) || (w_nextState == FALL_CHK);
      if (TOGGLE) begin
         w_startNext = r_start ^ w_pressEvt;
      end else begin
         w_startNext = w_btnDbNext;
      end
   end

   assign bus.btn_db        = r_btnDb;
   assign bus.press_pulse   = r_press;
   assign bus.release_pulse = r_release;
   assign bus.start         = r_start;

endmodule
